// File: rtl/avg_read_ctl.sv
// Read/write sequencer for a 4-byte averager: pops four bytes from a fall-through FIFO,
// then writes the averaged result to the next RAM location, wrapping once per frame.
module avg_read_ctl #(
  parameter int RAM_DEPTH = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              clk_2,
  input  logic              reset_n,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic              ram_busy,
  output logic              rd_fifo,
  output logic              b1,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              frame_done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              frame_done_q, frame_done_d;

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Handshakes: a byte transfers on any cycle with rd_fifo=1 (FIFO valid = !fifo_empty);
  // a RAM write transfers on any cycle with ram_wr=1 (RAM ready = !ram_busy).
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    frame_done_d = 1'b0;
    rd_fifo      = (state_q == READ) && !fifo_empty;
    b1           = rd_fifo && (cnt_q == 2'd0);
    ram_wr       = (state_q == WRITE) && !ram_busy;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = READ;
          cnt_d   = 2'd0;
        end
      end
      READ: begin
        if (rd_fifo) begin
          if (cnt_q == 2'd3) begin
            state_d = WRITE;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      WRITE: begin
        // en is only consulted here, so dropping it never abandons a group mid-way.
        if (ram_wr) begin
          addr_d       = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
          frame_done_d = (addr_q == LAST_ADDR);
          state_d      = en ? READ : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  assign ram_addr   = addr_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_avg_read_ctl.sv
// Bench for avg_read_ctl: a FIFO/averager/RAM model around the DUT with a write scoreboard,
// plus one task per scenario.
module tb_avg_read_ctl;

  localparam int DEPTH = 32;

  logic       clk_2 = 1'b0;
  logic       reset_n;
  logic       en;
  logic       fifo_empty;
  logic       ram_busy;
  logic       rd_fifo;
  logic       b1;
  logic       ram_wr;
  logic [4:0] ram_addr;
  logic       frame_done;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [9:0] acc;
  int         pop_idx;
  int         exp_addr;
  logic       fd_exp;
  logic       stall;
  int         n_wr;
  int         n_fd;

  avg_read_ctl #(.RAM_DEPTH(DEPTH), .ADDR_W(5)) dut (
    .clk_2      (clk_2),
    .reset_n    (reset_n),
    .en         (en),
    .fifo_empty (fifo_empty),
    .ram_busy   (ram_busy),
    .rd_fifo    (rd_fifo),
    .b1         (b1),
    .ram_wr     (ram_wr),
    .ram_addr   (ram_addr),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  always #5 clk_2 = ~clk_2;

  // FIFO driver, averager model and RAM-write scoreboard; inputs settle at negedge+1, sample at +2.
  always begin
    logic exp_b1;
    logic [7:0] head;
    logic [7:0] e;
    @(negedge clk_2);
    #1;
    fifo_empty = stall || (fifo_q.size() == 0);
    #1;
    if (reset_n === 1'b1) begin
      head = (fifo_q.size() > 0) ? fifo_q[0] : 8'd0;
      checks++;
      if (rd_fifo && fifo_empty) begin
        errors++;
        $display("FAIL pop_on_empty: rd_fifo=%b fifo_empty=%b", rd_fifo, fifo_empty);
      end
      checks++;
      if (rd_fifo && ram_wr) begin
        errors++;
        $display("FAIL rd_and_wr: rd_fifo=%b ram_wr=%b", rd_fifo, ram_wr);
      end
      exp_b1 = rd_fifo && (pop_idx % 4 == 0);
      checks++;
      if (b1 !== exp_b1) begin
        errors++;
        $display("FAIL b1: got %b expected %b (pop %0d)", b1, exp_b1, pop_idx);
      end
      checks++;
      if (frame_done !== fd_exp) begin
        errors++;
        $display("FAIL frame_done: got %b expected %b", frame_done, fd_exp);
      end
      if (frame_done === 1'b1) n_fd++;
      fd_exp = 1'b0;
      if (rd_fifo === 1'b1 && fifo_q.size() > 0) begin
        acc = b1 ? {2'b00, head} : acc + {2'b00, head};
        pop_idx++;
        void'(fifo_q.pop_front());
      end
      if (ram_wr === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%0d data=%0d expected no write", ram_addr, acc[9:2]);
        end else begin
          e = exp_q.pop_front();
          if (acc[9:2] !== e || ram_addr !== 5'(exp_addr)) begin
            errors++;
            $display("FAIL ram_write: got addr=%0d data=%0d expected addr=%0d data=%0d",
                     ram_addr, acc[9:2], exp_addr, e);
          end
        end
        fd_exp   = (exp_addr == DEPTH - 1);
        exp_addr = (exp_addr + 1) % DEPTH;
        n_wr++;
      end
    end
  end

  task automatic push_group(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    int s;
    fifo_q.push_back(a);
    fifo_q.push_back(b);
    fifo_q.push_back(c);
    fifo_q.push_back(d);
    s = int'(a) + int'(b) + int'(c) + int'(d);
    exp_q.push_back(8'(s / 4));
  endtask

  task automatic push_random_group();
    push_group(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  task automatic clear_model();
    fifo_q.delete();
    exp_q.delete();
    acc      = '0;
    pop_idx  = 0;
    exp_addr = 0;
    fd_exp   = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_2);
      #3;
      if (exp_q.size() == 0 && fifo_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    en       = 1'b0;
    ram_busy = 1'b0;
    stall    = 1'b0;
    n_wr     = 0;
    n_fd     = 0;
    clear_model();
    repeat (3) @(negedge clk_2);
    #3;
    checks++;
    if ({rd_fifo, b1, ram_wr, frame_done} !== 4'b0000 || ram_addr !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%b b1=%b wr=%b fd=%b addr=%0d expected all 0",
               rd_fifo, b1, ram_wr, frame_done, ram_addr);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [5:0] rd_v, b1_v, wr_v;
    push_group(8'd10, 8'd20, 8'd30, 8'd40);
    repeat (3) begin
      @(negedge clk_2);
      #3;
      checks++;
      if (rd_fifo !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_pop: rd_fifo=%b expected 0 with en=0", rd_fifo);
      end
    end
    @(negedge clk_2);
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #3;
      rd_v[i] = rd_fifo;
      b1_v[i] = b1;
      wr_v[i] = ram_wr;
      if (i == 5) begin
        checks++;
        if (ram_addr !== 5'd0) begin
          errors++;
          $display("FAIL basic_wr_addr: got %0d expected 0", ram_addr);
        end
      end
      @(negedge clk_2);
    end
    en = 1'b0;
    #3;
    checks++;
    if (rd_v !== 6'b011110 || b1_v !== 6'b000010 || wr_v !== 6'b100000) begin
      errors++;
      $display("FAIL basic_pattern: rd=%b b1=%b wr=%b expected rd=011110 b1=000010 wr=100000",
               rd_v, b1_v, wr_v);
    end
    checks++;
    if (ram_addr !== 5'd1) begin
      errors++;
      $display("FAIL basic_addr_after: got %0d expected 1", ram_addr);
    end
  endtask

  task automatic test_stall();
    int pops = 0;
    int wr = 0;
    int stall_n = 0;
    en = 1'b1;
    push_group(8'd3, 8'd250, 8'd77, 8'd128);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk_2);
      stall = (pops == 2 && stall_n < 3);
      #3;
      if (stall) begin
        checks++;
        if (rd_fifo !== 1'b0) begin
          errors++;
          $display("FAIL stall_pop: rd_fifo=%b expected 0 while empty", rd_fifo);
        end
        stall_n++;
      end
      if (rd_fifo === 1'b1) pops++;
      if (ram_wr === 1'b1) wr++;
    end
    stall = 1'b0;
    en    = 1'b0;
    checks++;
    if (pops != 4 || wr != 1 || stall_n != 3) begin
      errors++;
      $display("FAIL stall_counts: pops=%0d writes=%0d stalls=%0d expected 4/1/3", pops, wr, stall_n);
    end
  endtask

  task automatic test_busy();
    int pops = 0;
    int wr = 0;
    int busy_n = 0;
    bit seen = 1'b0;
    int start_addr;
    start_addr = exp_addr;
    ram_busy   = 1'b1;
    en         = 1'b1;
    push_random_group();
    push_random_group();
    for (int cyc = 0; cyc < 40 && wr < 2; cyc++) begin
      @(negedge clk_2);
      if (pops == 4 && busy_n == 2) ram_busy = 1'b0;
      #3;
      if (pops == 4 && busy_n < 2) begin
        checks++;
        if (ram_wr !== 1'b0 || rd_fifo !== 1'b0) begin
          errors++;
          $display("FAIL busy_hold: ram_wr=%b rd_fifo=%b expected 0/0", ram_wr, rd_fifo);
        end
        busy_n++;
      end else if (pops == 4 && busy_n == 2 && !seen) begin
        checks++;
        if (ram_wr !== 1'b1) begin
          errors++;
          $display("FAIL busy_release: ram_wr=%b expected 1", ram_wr);
        end
        seen = 1'b1;
      end
      if (rd_fifo === 1'b1) pops++;
      if (ram_wr === 1'b1) wr++;
    end
    en       = 1'b0;
    ram_busy = 1'b0;
    @(negedge clk_2);
    #3;
    checks++;
    if (wr != 2 || ram_addr !== 5'((start_addr + 2) % DEPTH)) begin
      errors++;
      $display("FAIL busy_result: writes=%0d addr=%0d expected 2 writes addr=%0d",
               wr, ram_addr, (start_addr + 2) % DEPTH);
    end
  endtask

  task automatic test_en_drop();
    int pops = 0;
    int wr = 0;
    bit ok;
    en = 1'b1;
    push_random_group();
    push_random_group();
    for (int cyc = 0; cyc < 30 && wr < 1; cyc++) begin
      @(negedge clk_2);
      #3;
      if (rd_fifo === 1'b1) pops++;
      if (ram_wr === 1'b1) wr++;
      if (pops >= 1) en = 1'b0;
    end
    checks++;
    if (pops != 4 || wr != 1) begin
      errors++;
      $display("FAIL en_drop_group: pops=%0d writes=%0d expected 4/1", pops, wr);
    end
    repeat (6) begin
      @(negedge clk_2);
      #3;
      checks++;
      if (rd_fifo !== 1'b0) begin
        errors++;
        $display("FAIL en_drop_idle: rd_fifo=%b expected 0 after group with en=0", rd_fifo);
      end
    end
    @(negedge clk_2);
    en = 1'b1;
    @(negedge clk_2);
    en = 1'b0;
    wait_drain(40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL en_pulse_drain: %0d writes pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int pops = 0;
    bit ok;
    int wr0;
    en = 1'b1;
    push_random_group();
    for (int cyc = 0; cyc < 20 && pops < 3; cyc++) begin
      @(negedge clk_2);
      #3;
      if (rd_fifo === 1'b1) pops++;
    end
    #1;
    reset_n = 1'b0;
    clear_model();
    #1;
    checks++;
    if ({rd_fifo, b1, ram_wr, frame_done} !== 4'b0000 || ram_addr !== 5'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: rd=%b b1=%b wr=%b fd=%b addr=%0d expected all 0",
               rd_fifo, b1, ram_wr, frame_done, ram_addr);
    end
    repeat (2) @(negedge clk_2);
    #3;
    push_group(8'd8, 8'd8, 8'd8, 8'd8);
    wr0     = n_wr;
    reset_n = 1'b1;
    wait_drain(30, ok);
    en = 1'b0;
    @(negedge clk_2);
    #3;
    checks++;
    if (!ok || n_wr != wr0 + 1 || ram_addr !== 5'd1) begin
      errors++;
      $display("FAIL mid_reset_recover: drained=%0d writes=%0d addr=%0d expected 1/1/1",
               ok, n_wr - wr0, ram_addr);
    end
  endtask

  task automatic test_frame();
    bit ok;
    int wr0, fd0;
    @(negedge clk_2);
    #3;
    reset_n = 1'b0;
    clear_model();
    @(negedge clk_2);
    #3;
    reset_n = 1'b1;
    wr0 = n_wr;
    fd0 = n_fd;
    for (int g = 0; g < DEPTH; g++) push_random_group();
    en = 1'b1;
    wait_drain(400, ok);
    repeat (3) @(negedge clk_2);
    #3;
    en = 1'b0;
    checks++;
    if (!ok || n_wr - wr0 != DEPTH || n_fd - fd0 != 1 || ram_addr !== 5'd0) begin
      errors++;
      $display("FAIL frame: drained=%0d writes=%0d pulses=%0d addr=%0d expected 1/%0d/1/0",
               ok, n_wr - wr0, n_fd - fd0, ram_addr, DEPTH);
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk_2);
      en       = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      ram_busy = ($urandom_range(0, 2) == 0);
      if (fifo_q.size() < 8 && $urandom_range(0, 3) == 0) push_random_group();
    end
    @(negedge clk_2);
    en       = 1'b1;
    stall    = 1'b0;
    ram_busy = 1'b0;
    wait_drain(200, ok);
    en = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL random_drain: %0d writes and %0d bytes pending expected 0",
               exp_q.size(), fifo_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_busy();
    test_en_drop();
    test_reset_mid();
    test_frame();
    test_random();
    repeat (2) @(negedge clk_2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
